cpsr_flag_writer: RTL

//  Producer side of the condition-flag path: computes N/Z/C/V for flag-setting ops in EX, carries

---
 rtl/cpsr_flag_writer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpsr_flag_writer.sv
// Condition-flag producer: computes NZCV in EX, shadows them to writeback,
// commits architectural flags and forwards the youngest in-flight values.
module cpsr_flag_writer #(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 2,
    localparam int CW        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [1:0]       ex_op_class,
    input  logic [WIDTH-1:0] ex_operand_a,
    input  logic [WIDTH-1:0] ex_operand_b,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_carry_out,
    input  logic             ex_shift_carry,
    input  logic             stall,
    input  logic             flush,
    output logic             negative,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             fwd_n,
    output logic             fwd_z,
    output logic             fwd_c,
    output logic             fwd_v,
    output logic             flags_pending,
    output logic [CW-1:0]    pending_count
);

    typedef struct packed {
        logic vld;
        logic n;
        logic z;
        logic c;
        logic v;
        logic kv;
    } stg_t;

    stg_t stg_q [PIPE_DEPTH];
    stg_t stg_d [PIPE_DEPTH];
    stg_t cap_e;
    logic n_q, z_q, c_q, v_q;
    logic n_d, z_d, c_d, v_d;
    logic cap, adv;
    logic am, bm, rm;
    logic unused_ok;

    assign am = ex_operand_a[WIDTH-1];
    assign bm = ex_operand_b[WIDTH-1];
    assign rm = ex_result[WIDTH-1];
    assign unused_ok = ^{ex_operand_a[WIDTH-2:0], ex_operand_b[WIDTH-2:0]};

    assign cap = ex_valid & ex_set_flags & (ex_op_class != 2'b11)
               & ~stall & ~flush;
    assign adv = ~stall | flush;

    always_comb begin
        cap_e     = '0;
        cap_e.vld = cap;
        cap_e.n   = rm;
        cap_e.z   = ~|ex_result;
        case (ex_op_class)
            2'b01: begin
                cap_e.c = ex_carry_out;
                cap_e.v = (am == bm) & (rm != am);
            end
            2'b10: begin
                cap_e.c = ex_carry_out;
                cap_e.v = (am != bm) & (rm != am);
            end
            default: begin
                cap_e.c  = ex_shift_carry;
                cap_e.kv = 1'b1;
            end
        endcase
    end

    always_comb begin
        stg_d = stg_q;
        n_d   = n_q;
        z_d   = z_q;
        c_d   = c_q;
        v_d   = v_q;
        if (adv) begin
            if (stg_q[PIPE_DEPTH-1].vld) begin
                n_d = stg_q[PIPE_DEPTH-1].n;
                z_d = stg_q[PIPE_DEPTH-1].z;
                c_d = stg_q[PIPE_DEPTH-1].c;
                v_d = stg_q[PIPE_DEPTH-1].kv ? v_q : stg_q[PIPE_DEPTH-1].v;
            end
            stg_d[0] = cap_e;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                stg_d[i] = stg_q[i-1];
                if (flush) stg_d[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg_q[i] <= '0;
            n_q <= 1'b0;
            z_q <= 1'b0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) stg_q[i] <= stg_d[i];
            n_q <= n_d;
            z_q <= z_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    // Walk oldest to youngest so a logic op's kept V sees the next-older value.
    always_comb begin
        fwd_n         = n_q;
        fwd_z         = z_q;
        fwd_c         = c_q;
        fwd_v         = v_q;
        pending_count = '0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (stg_q[i].vld) begin
                fwd_n = stg_q[i].n;
                fwd_z = stg_q[i].z;
                fwd_c = stg_q[i].c;
                fwd_v = stg_q[i].kv ? fwd_v : stg_q[i].v;
            end
            pending_count = pending_count + CW'(stg_q[i].vld);
        end
    end

    assign flags_pending = |pending_count;
    assign negative      = n_q;
    assign zero          = z_q;
    assign carry         = c_q;
    assign overflow      = v_q;

endmodule
